// File: rtl/mb8_arb.sv
// Round-robin arbiter sharing one pipelined 8x8 signed multiplier among NREQ requesters.
// Define MB8_ARB_GRANT_CNT_EN to build the per-requester saturating grant counters.
module mb8_arb #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2,
  parameter int IDW     = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_mx,
  input  logic [NREQ*WIDTH-1:0] req_my,
  output logic [WIDTH-1:0]      mul_mx,
  output logic [WIDTH-1:0]      mul_my,
  input  logic [2*WIDTH-1:0]    mul_product,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_product,
  output logic                  idle,
  output logic [NREQ*16-1:0]    grant_cnt
);

  logic [IDW-1:0]     ptr;
  logic               gnt_any;
  logic [IDW-1:0]     gnt_id;
  logic [MUL_LAT-1:0] stg_v;
  logic [IDW-1:0]     stg_id [MUL_LAT];

  // Rotating search starting at ptr; a grant always coincides with acceptance.
  always_comb begin : arb
    int j;
    gnt_any = 1'b0;
    gnt_id  = '0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(j);
      end
    end
    if (RST) gnt_any = 1'b0;
  end

  assign req_ready = gnt_any ? (NREQ'(1) << gnt_id) : '0;
  assign mul_mx    = gnt_any ? req_mx[int'(gnt_id)*WIDTH +: WIDTH] : '0;
  assign mul_my    = gnt_any ? req_my[int'(gnt_id)*WIDTH +: WIDTH] : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stg_v <= '0;
      for (int k = 0; k < MUL_LAT; k++) stg_id[k] <= '0;
    end else begin
      stg_v[0]  <= gnt_any;
      stg_id[0] <= gnt_id;
      for (int k = 1; k < MUL_LAT; k++) begin
        stg_v[k]  <= stg_v[k-1];
        stg_id[k] <= stg_id[k-1];
      end
    end
  end

  // The last tag stage lines up with the multiplier's registered product.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_valid   <= '0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      rsp_valid <= stg_v[MUL_LAT-1] ? (NREQ'(1) << stg_id[MUL_LAT-1]) : '0;
      rsp_id    <= stg_id[MUL_LAT-1];
      if (stg_v[MUL_LAT-1]) rsp_product <= mul_product;
    end
  end

  assign idle = ~|stg_v & ~|rsp_valid;

`ifdef MB8_ARB_GRANT_CNT_EN
  logic [15:0] cnt [NREQ];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_any && gnt_id == IDW'(i) && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
    assign grant_cnt[gi*16 +: 16] = cnt[gi];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mb8_arb.sv
// Scoreboard bench for mb8_arb: random and directed requests against a rule-level arbiter
// model and an integer-arithmetic product model, with a behavioural 2-stage multiplier.
module tb_mb8_arb;
  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int MUL_LAT = 2;
  localparam int IDW     = 2;
`ifdef MB8_ARB_GRANT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_mx = '0;
  logic [NREQ*WIDTH-1:0] req_my = '0;
  logic [WIDTH-1:0]      mul_mx, mul_my;
  logic [2*WIDTH-1:0]    mul_product;
  logic [NREQ-1:0]       rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_product;
  logic                  idle;
  logic [NREQ*16-1:0]    grant_cnt;

  mb8_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_mx(req_mx), .req_my(req_my), .mul_mx(mul_mx), .mul_my(mul_my),
    .mul_product(mul_product), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .idle(idle), .grant_cnt(grant_cnt)
  );

  always #5 CLK = ~CLK;

  // Multiplier: registered operands, registered product.
  logic [WIDTH-1:0] m_x, m_y;
  always @(posedge CLK) begin
    m_x         <= mul_mx;
    m_y         <= mul_my;
    mul_product <= {{8{m_x[7]}}, m_x} * {{8{m_y[7]}}, m_y};
  end

  typedef struct {
    int          id;
    logic [15:0] prod;
    int          exp_cyc;
  } exp_t;

  exp_t            q[$];
  int              nvec = 0;
  int              nfail = 0;
  int              cyc = 0;
  bit              checking = 1'b0;
  int              model_ptr = 0;
  int              model_cnt [NREQ];
  logic [NREQ-1:0] acc_mask = '0;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin : mon
    exp_t             e;
    logic [NREQ-1:0]  oh;
    logic [NREQ-1:0]  exp_ready;
    logic [7:0]       exp_mx, exp_my;
    logic [NREQ*16-1:0] exp_cnt;
    int               g, best, d, a, b;
    if (checking) begin
      nvec++;
      if (idle !== (q.size() == 0)) begin
        nfail++;
        $display("FAIL idle cyc=%0d actual=%b required=%b", cyc, idle, q.size() == 0);
      end

      if (rsp_valid !== '0) begin
        nvec++;
        if (q.size() == 0) begin
          nfail++;
          $display("FAIL rsp_unexpected cyc=%0d actual rsp_valid=%b required=0", cyc, rsp_valid);
        end else begin
          e = q.pop_front();
          oh = '0;
          oh[e.id] = 1'b1;
          if (rsp_valid !== oh || rsp_id !== IDW'(e.id) || rsp_product !== e.prod || cyc != e.exp_cyc) begin
            nfail++;
            $display("FAIL rsp cyc=%0d actual valid=%b id=%0d prod=%h required valid=%b id=%0d prod=%h cyc=%0d",
                     cyc, rsp_valid, rsp_id, rsp_product, oh, e.id, e.prod, e.exp_cyc);
          end
        end
      end else if (q.size() > 0 && q[0].exp_cyc <= cyc) begin
        nvec++;
        nfail++;
        $display("FAIL rsp_missing cyc=%0d actual rsp_valid=0 required id=%0d prod=%h", cyc, q[0].id, q[0].prod);
        void'(q.pop_front());
      end

      // Winner is the valid requester at the smallest cyclic distance from the pointer.
      g = -1;
      best = NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i]) begin
          d = (i - model_ptr + NREQ) % NREQ;
          if (d < best) begin
            best = d;
            g = i;
          end
        end
      end
      if (RST) g = -1;
      exp_ready = '0;
      exp_mx = '0;
      exp_my = '0;
      if (g >= 0) begin
        exp_ready[g] = 1'b1;
        exp_mx = req_mx[g*8 +: 8];
        exp_my = req_my[g*8 +: 8];
      end
      nvec++;
      if (req_ready !== exp_ready || mul_mx !== exp_mx || mul_my !== exp_my) begin
        nfail++;
        $display("FAIL grant cyc=%0d actual ready=%b mx=%h my=%h required ready=%b mx=%h my=%h",
                 cyc, req_ready, mul_mx, mul_my, exp_ready, exp_mx, exp_my);
      end

      exp_cnt = '0;
      if (CNT_EN)
        for (int i = 0; i < NREQ; i++) exp_cnt[i*16 +: 16] = 16'(model_cnt[i]);
      nvec++;
      if (grant_cnt !== exp_cnt) begin
        nfail++;
        $display("FAIL grant_cnt cyc=%0d actual=%h required=%h", cyc, grant_cnt, exp_cnt);
      end

      acc_mask = '0;
      if (RST) begin
        q.delete();
        model_ptr = 0;
        for (int i = 0; i < NREQ; i++) model_cnt[i] = 0;
      end else if (g >= 0) begin
        a = int'($signed(exp_mx));
        b = int'($signed(exp_my));
        e.id = g;
        e.prod = 16'(a * b);
        e.exp_cyc = cyc + 1 + MUL_LAT;
        q.push_back(e);
        model_ptr = (g + 1) % NREQ;
        if (model_cnt[g] < 65535) model_cnt[g]++;
        acc_mask[g] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] x, input logic [7:0] y);
    req_valid[i] = v;
    req_mx[i*8 +: 8] = x;
    req_my[i*8 +: 8] = y;
  endtask

  task automatic refresh_accepted();
    for (int i = 0; i < NREQ; i++)
      if (acc_mask[i]) set_req(i, 1'b1, 8'($urandom), 8'($urandom));
  endtask

  initial begin
    int prob;
    for (int i = 0; i < NREQ; i++) model_cnt[i] = 0;
    RST = 1'b1;
    tick();
    checking = 1'b1;
    tick();
    RST = 1'b0;

    // Single request: 7*6.
    set_req(0, 1'b1, 8'd7, 8'd6);
    tick();
    req_valid = '0;
    repeat (5) tick();

    // Signed operands on requester 2: -3*5.
    set_req(2, 1'b1, 8'hFD, 8'd5);
    tick();
    req_valid = '0;
    repeat (5) tick();

    // All requesters continuously valid.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'($urandom), 8'($urandom));
    repeat (12) begin
      tick();
      refresh_accepted();
    end
    req_valid = '0;
    repeat (5) tick();

    // Pointer skip: move pointer to 2, then only 0 and 3 compete.
    set_req(1, 1'b1, 8'd3, 8'd3);
    tick();
    req_valid = '0;
    set_req(0, 1'b1, 8'h80, 8'h80);
    set_req(3, 1'b1, 8'h7F, 8'h81);
    repeat (3) begin
      tick();
      refresh_accepted();
    end
    req_valid = '0;
    repeat (5) tick();

    // Reset with two ops in flight; requests held during reset must not be accepted.
    set_req(0, 1'b1, 8'd11, 8'd12);
    set_req(1, 1'b1, 8'd13, 8'd14);
    tick();
    tick();
    req_valid = '1;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    req_valid = '0;
    repeat (5) tick();
    set_req(1, 1'b1, 8'd2, 8'd9);
    set_req(3, 1'b1, 8'd4, 8'd9);
    tick();
    req_valid = '0;
    repeat (5) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;

    // Five accepts on requester 1, then clear.
    set_req(1, 1'b1, 8'd1, 8'd1);
    repeat (5) begin
      tick();
      refresh_accepted();
    end
    req_valid = '0;
    repeat (4) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();

    // Random traffic with occasional resets.
    prob = 50;
    for (int n = 0; n < 800; n++) begin
      if (n % 100 == 0) prob = (n / 100) % 2 == 0 ? 100 : $urandom_range(10, 90);
      RST = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] || acc_mask[i])
          set_req(i, ($urandom_range(0, 99) < prob), 8'($urandom), 8'($urandom));
      tick();
    end
    RST = 1'b0;
    req_valid = '0;
    repeat (6) tick();

    nvec++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain actual pending=%0d required=0", q.size());
    end
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/mb8_arb.md
Name: mb8_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined 8x8 signed multiplier (registered inputs, registered product, MUL_LAT=2) among NREQ requesters.
- Per requester: valid/ready request interface. One operand pair issued per cycle.
- A tag pipeline tracks which requester owns each in-flight product. The completed product is returned on a shared registered response bus with a one-hot valid.
- Sits between the PE-side operand sources and the multiplier instance in the multiplier test/evaluation wrappers.

Parameters:
- WIDTH, 8, operand width; product width is 2*WIDTH.
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 2, clock edges from operands presented on mul_mx/mul_my to product valid on mul_product.
- IDW, 2, requester index width, equal to clog2(NREQ).

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant; one-hot or zero.
- req_mx  input  NREQ*WIDTH  multiplicand, requester i at bits [i*WIDTH +: WIDTH].
- req_my  input  NREQ*WIDTH  multiplier operand, same packing.
- mul_mx  output  WIDTH  operand to multiplier mx input.
- mul_my  output  WIDTH  operand to multiplier my input.
- mul_product  input  2*WIDTH  multiplier registered product.
- rsp_valid  output  NREQ  one-hot, one-cycle pulse marking the owner of rsp_product.
- rsp_id  output  IDW  binary index of the rsp_valid owner.
- rsp_product  output  2*WIDTH  returned product.
- idle  output  1  high when no op is in flight and rsp_valid is 0.
- grant_cnt  output  NREQ*16  per-requester accepted-op counters (see Optional Feature).

Behaviour:
- Arbitration (combinational from req_valid and the ptr register):
  - Grant the first requester i with req_valid[i]=1, searching ptr, ptr+1, ... modulo NREQ.
  - req_ready = one-hot of that requester, or 0 if no request.
  - req_ready is forced to 0 while RST=1.
- Handshake:
  - Op i is accepted at a rising edge where req_valid[i] && req_ready[i].
  - A requester holds mx/my stable while valid and not ready; valid is not withdrawn until accepted.
- Issue:
  - mul_mx/mul_my = operands of the granted requester, combinational.
  - Both are 0 when there is no grant.
- Pointer:
  - On acceptance of i, ptr <= (i+1) mod NREQ.
  - With no acceptance, ptr holds.
- Tag pipeline: MUL_LAT stages of {v, id}.
  - Stage 0 loads {accept, granted id} every edge.
  - Stage k loads stage k-1.
- Response:
  - At each edge, rsp_valid <= onehot(stage[MUL_LAT-1].id) if stage[MUL_LAT-1].v, else 0.
  - rsp_id <= stage id.
  - rsp_product <= mul_product when stage valid, else holds its previous value.
- Latency:
  - Op accepted at edge E0 is visible on rsp_* in the cycle after edge E0+MUL_LAT, i.e. 3 edges for MUL_LAT=2.
  - rsp_valid is high for exactly 1 cycle. There is no response backpressure; the requester must capture it.
- Throughput: 1 op/cycle sustained, with responses returned in issue order.
- Fairness: with all NREQ requests continuously asserted, grants cycle 0,1,2,3,0,... Any continuously asserted requester waits at most NREQ-1 cycles.
- Arithmetic: the arbiter does not modify the product; width and sign come from the multiplier.
- idle = ~|stage.v & ~|rsp_valid.
- Reset:
  - ptr=0, all tag stages v=0/id=0.
  - rsp_valid=0, rsp_id=0, rsp_product=0, grant_cnt=0.
  - Ops in flight when RST asserts are dropped: no rsp_valid for them after reset.
  - No op is accepted in a cycle with RST=1.
- Simultaneous events: accept, pipeline advance and response output all happen on the same edge with no conflict.
- Single requester: one requester alone gets back-to-back grants each cycle.

Optional Feature:
- Macro MB8_ARB_GRANT_CNT_EN.
- Defined:
  - grant_cnt[i*16 +: 16] increments on each acceptance for requester i.
  - The counter saturates at 16'hFFFF.
  - Cleared by RST.
- Undefined: grant_cnt is tied to 0 and no counter flops exist.

Test Plan:
- Reset, then a single request: RST 2 cycles; req0 mx=8'd7, my=8'd6 for 1 cycle -> req_ready=4'b0001; rsp_valid=4'b0001, rsp_id=0, rsp_product=16'd42 exactly 3 edges after acceptance; idle returns to 1.
- Signed operands: req2 mx=8'hFD (-3), my=8'd5 -> rsp_valid=4'b0100, rsp_product=16'hFFF1 (-15).
- Round-robin: all 4 valid continuously with distinct operands -> grants 0,1,2,3,0,1,... and rsp_id sequence 0,1,2,3,... with the correct products, 1 per cycle.
- Pointer skip: ptr=2, only req0 and req3 valid -> req3 granted first, then req0, then req3.
- Reset mid-flight: accept 2 ops, assert RST on the next edge -> no rsp_valid pulses afterward; ptr=0, idle=1.
- With MB8_ARB_GRANT_CNT_EN: 5 accepts on req1 -> grant_cnt[31:16]=5, other counts 0; after RST all 0.
